// File: rtl/axis_sync_fifo.sv
// Single-clock first-word-fall-through AXI-Stream FIFO with registered ready, valid and fill level.
// Optional high-water-mark tracking (hwm/hwm_clr) is enabled by defining AXIS_FIFO_HWM_EN.
module axis_sync_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
`ifdef AXIS_FIFO_HWM_EN
  input  logic                  hwm_clr,
  output logic [ADDR_WIDTH:0]   hwm,
`endif
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [Depth];

  logic [ADDR_WIDTH:0] r_wr_ptr, r_rd_ptr, r_level;
  logic [ADDR_WIDTH:0] w_wr_ptr_d, w_rd_ptr_d, w_level_d;
  logic                r_full, r_empty, r_s_ready, r_m_valid;
  logic                w_full_d, w_empty_d;
  logic                w_wr_en, w_rd_en;

  always_comb begin
    w_wr_en    = s_axis_tvalid & r_s_ready;
    w_rd_en    = r_m_valid & m_axis_tready;
    w_wr_ptr_d = r_wr_ptr + {{ADDR_WIDTH{1'b0}}, w_wr_en};
    w_rd_ptr_d = r_rd_ptr + {{ADDR_WIDTH{1'b0}}, w_rd_en};
    w_level_d  = w_wr_ptr_d - w_rd_ptr_d;
    // Level never exceeds Depth, so its MSB alone marks the full condition.
    w_full_d   = w_level_d[ADDR_WIDTH];
    w_empty_d  = (w_level_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_m_valid <= 1'b0;
      r_s_ready <= 1'b0;
    end else begin
      r_wr_ptr  <= w_wr_ptr_d;
      r_rd_ptr  <= w_rd_ptr_d;
      r_level   <= w_level_d;
      r_full    <= w_full_d;
      r_empty   <= w_empty_d;
      r_m_valid <= ~w_empty_d;
      r_s_ready <= ~w_full_d;
    end
  end

  // Storage is deliberately left unreset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= s_axis_tdata;
    end
  end

  assign m_axis_tdata  = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
  assign m_axis_tvalid = r_m_valid;
  assign s_axis_tready = r_s_ready;
  assign level         = r_level;
  assign full          = r_full;
  assign empty         = r_empty;

`ifdef AXIS_FIFO_HWM_EN
  logic [ADDR_WIDTH:0] r_hwm, w_hwm_d;

  always_comb begin
    w_hwm_d = r_hwm;
    if (hwm_clr) begin
      w_hwm_d = w_level_d;
    end else if (w_level_d > r_hwm) begin
      w_hwm_d = w_level_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hwm <= '0;
    end else begin
      r_hwm <= w_hwm_d;
    end
  end

  assign hwm = r_hwm;
`endif

endmodule
